// File: rtl/sorted_byte_buffer_pkg.sv
// Shared types for the sorted byte buffer:
// FSM states, slot select codes and default sizes.
package sorted_buf_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_UPPER,
        OP_LOWER
    } slot_op_t;

endpackage

// File: rtl/sorted_byte_buffer_if.sv
// Input and output valid/ready streams of the sorted byte buffer.
// master = producer/consumer side, slave = buffer side.
interface sorted_byte_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, count
    );

endinterface

// File: rtl/sorted_byte_buffer_slot.sv
// One storage slot of the insertion-sort array.
// Reports slot >= in_data and loads from one of four sources.
module sort_slot
    import sorted_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  slot_op_t         op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    output logic [WIDTH-1:0] q,
    output logic             ge
);

    assign ge = (q >= in_data);

    // Slot register: hold, take the new word, shift down on insert, shift up on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            unique case (op)
                OP_HOLD:  q <= q;
                OP_LOAD:  q <= in_data;
                OP_UPPER: q <= upper;
                OP_LOWER: q <= lower;
            endcase
        end
    end

endmodule

// File: rtl/sorted_byte_buffer.sv
// Collects a burst of up to DEPTH bytes, keeps them sorted largest-first
// as they arrive, then streams them out with out_last on the final word.
module sorted_byte_buffer
    import sorted_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic                 clk,
    input logic                 rst,
    sorted_byte_buffer_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic [WIDTH-1:0] slot    [DEPTH];
    logic [WIDTH-1:0] upper_w [DEPTH];
    logic [WIDTH-1:0] lower_w [DEPTH];
    slot_op_t         op      [DEPTH];
    logic [DEPTH-1:0] ge;
    logic [CW-1:0]    k;
    logic [CW-1:0]    cnt_inc;
    logic [CW-1:0]    cnt_dec;
    logic             accept;
    logic             pop;

    assign accept  = bus.in_valid && in_ready_q;
    assign pop     = out_valid_q && bus.out_ready;
    assign cnt_inc = count + 1'b1;
    assign cnt_dec = count - 1'b1;

    // Held slots are descending, so the ge bits form a prefix;
    // counting them gives the insert index (equal values stay ahead).
    always_comb begin
        k = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ge[i] && (i < int'(count))) begin
                k = k + 1'b1;
            end
        end
    end

    // Per-slot select: whole array shifts up on pop; on insert the
    // slot at k loads the word and everything below it shifts down.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            op[i] = OP_HOLD;
            if (pop) begin
                op[i] = OP_LOWER;
            end else if (accept) begin
                if (i == int'(k)) begin
                    op[i] = OP_LOAD;
                end else if (i > int'(k)) begin
                    op[i] = OP_UPPER;
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign upper_w[i] = '0;
        end else begin : g_mid
            assign upper_w[i] = slot[i-1];
        end
        if (i == DEPTH - 1) begin : g_tail
            assign lower_w[i] = '0;
        end else begin : g_body
            assign lower_w[i] = slot[i+1];
        end

        sort_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .op      (op[i]),
            .in_data (bus.in_data),
            .upper   (upper_w[i]),
            .lower   (lower_w[i]),
            .q       (slot[i]),
            .ge      (ge[i])
        );
    end

    // FSM with counter and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        count <= cnt_inc;
                        if (bus.in_last || (cnt_inc == CW'(DEPTH))) begin
                            state       <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (cnt_inc == CW'(1));
                        end
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        count <= cnt_dec;
                        if (out_last_q) begin
                            state       <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_last_q <= (cnt_dec == CW'(1));
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = slot[0];
    assign bus.count     = count;

endmodule

// File: tb/tb_sorted_byte_buffer.sv
// Randomised and directed bench for sorted_byte_buffer against a
// queue-based model of the burst (sorted insert, pop-front drain).
module tb_sorted_byte_buffer;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    sorted_byte_buffer_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    sorted_byte_buffer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    logic [7:0] held [$];
    bit         drain;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        held.delete();
        drain = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!drain));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(drain));
        chk({tag, ".count"}, 32'(bus.count), 32'(held.size()));
        if (drain && held.size() > 0) begin
            chk({tag, ".out_data"}, 32'(bus.out_data), 32'(held[0]));
            chk({tag, ".out_last"}, 32'(bus.out_last), 32'(held.size() == 1));
        end
    endtask

    // Called #1 after a rising edge: check, drive, clock, update model.
    task automatic step(input bit iv, input logic [7:0] d, input bit il,
                        input bit ordy, output bit acc);
        int k;
        check_outs("step");
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_last   = il;
        bus.out_ready = ordy;
        acc = iv && !drain;
        @(posedge clk);
        if (acc) begin
            k = 0;
            foreach (held[j]) if (held[j] >= d) k++;
            held.insert(k, d);
            if (il || held.size() == DEPTH) drain = 1'b1;
        end else if (drain && ordy) begin
            void'(held.pop_front());
            if (held.size() == 0) drain = 1'b0;
        end
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit il);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        while (!acc) begin
            step(1'b1, d, il, 1'b1, acc);
            guard++;
            if (guard > 50) begin
                chk("push_timeout", 32'(guard), 32'(0));
                return;
            end
        end
    endtask

    task automatic drain_all(input bit rnd);
        bit acc;
        int guard;
        guard = 0;
        while (drain) begin
            step(1'b0, 8'h00, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            guard++;
            if (guard > 100) begin
                chk("drain_timeout", 32'(guard), 32'(0));
                return;
            end
        end
    endtask

    initial begin
        bit acc;
        logic [7:0] d;
        int len;
        int guard;

        n_chk = 0;
        n_err = 0;
        model_clear();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst.out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst.out_data", 32'(bus.out_data), 32'(0));
        chk("rst.out_last", 32'(bus.out_last), 32'(0));
        chk("rst.count", 32'(bus.count), 32'(0));
        rst = 1'b0;

        // 1: basic sort
        push(8'h10, 0); push(8'h40, 0); push(8'h20, 0); push(8'h30, 1);
        chk("t1.first", 32'(bus.out_data), 32'(8'h40));
        drain_all(0);
        chk("t1.in_ready_after", 32'(bus.in_ready), 32'(1));

        // 2: auto-close on full, fifth word held by producer
        push(8'h11, 0); push(8'h55, 0); push(8'h33, 0); push(8'h22, 0);
        chk("t2.full_in_ready", 32'(bus.in_ready), 32'(0));
        chk("t2.full_count", 32'(bus.count), 32'(4));
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 50) begin
            step(1'b1, 8'h99, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("t2.fifth_count", 32'(bus.count), 32'(1));
        push(8'h44, 1);
        drain_all(0);

        // 3: equal values
        push(8'h07, 0); push(8'h07, 0); push(8'h03, 1);
        chk("t3.count3", 32'(bus.count), 32'(3));
        drain_all(0);

        // 4: unsigned extremes with stall
        push(8'hFF, 0); push(8'h00, 1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("t4.stall_data", 32'(bus.out_data), 32'(8'hFF));
        chk("t4.stall_count", 32'(bus.count), 32'(2));
        drain_all(0);

        // 5: single-word burst
        push(8'h5A, 1);
        chk("t5.out_last", 32'(bus.out_last), 32'(1));
        chk("t5.out_data", 32'(bus.out_data), 32'(8'h5A));
        drain_all(0);

        // 6: reset mid-drain
        push(8'h01, 0); push(8'h09, 0); push(8'h05, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("t6.before_rst", 32'(bus.count), 32'(2));
        rst = 1'b1;
        #1;
        chk("t6.rst_count", 32'(bus.count), 32'(0));
        chk("t6.rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("t6.rst_in_ready", 32'(bus.in_ready), 32'(1));
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(8'h80, 0); push(8'hC0, 0); push(8'h7F, 1);
        drain_all(0);

        // random bursts
        for (int b = 0; b < 60; b++) begin
            len = $urandom_range(1, 5);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 3));
                else d = 8'($urandom);
                acc = 1'b0;
                guard = 0;
                while (!acc && guard < 60) begin
                    step(1'($urandom_range(0, 3) != 0), d, w == len - 1,
                         1'($urandom_range(0, 1)), acc);
                    guard++;
                end
                if (!acc) chk("rand.accept_timeout", 32'(guard), 32'(0));
            end
            drain_all(1);
        end
        check_outs("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
